// File: rtl/matmul_mem_sequencer_pkg.sv
// rtl/matmul_mem_sequencer_pkg.sv - shared types, widths and address helper for the matmul sequencer
// Purpose: FSM state enum, datapath widths and the row-major element address helper.
// Ports: none (package).
package matmul_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } state_e;

   // Row-major element address; all arithmetic is 8-bit and wraps mod 256.
   function automatic logic [ADDR_W-1:0] elem_addr(
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] row,
      input logic [ADDR_W-1:0] col,
      input logic [ADDR_W-1:0] n
   );
      return base + row * n + col;
   endfunction

endpackage

// File: rtl/matmul_mem_sequencer_if.sv
// rtl/matmul_mem_sequencer_if.sv - four-port data memory bus between the sequencer and the memory
// Purpose: groups the write enables, addresses, write data and read data of ports 0-3.
// Modports: master (sequencer drives write_en/addr/datain, reads dataout),
//           slave  (memory side, drives dataout).
interface matmul_mem_sequencer_if;
   import matmul_pkg::*;

   logic              mem_write_en0, mem_write_en1, mem_write_en2, mem_write_en3;
   logic [ADDR_W-1:0] mem_addr0, mem_addr1, mem_addr2, mem_addr3;
   logic [DATA_W-1:0] mem_datain0, mem_datain1, mem_datain2, mem_datain3;
   logic [DATA_W-1:0] mem_dataout0, mem_dataout1, mem_dataout2, mem_dataout3;

   modport master (
      output mem_write_en0, mem_write_en1, mem_write_en2, mem_write_en3,
      output mem_addr0, mem_addr1, mem_addr2, mem_addr3,
      output mem_datain0, mem_datain1, mem_datain2, mem_datain3,
      input  mem_dataout0, mem_dataout1, mem_dataout2, mem_dataout3
   );

   modport slave (
      input  mem_write_en0, mem_write_en1, mem_write_en2, mem_write_en3,
      input  mem_addr0, mem_addr1, mem_addr2, mem_addr3,
      input  mem_datain0, mem_datain1, mem_datain2, mem_datain3,
      output mem_dataout0, mem_dataout1, mem_dataout2, mem_dataout3
   );

endinterface

// File: rtl/matmul_mem_sequencer_dual_mac.sv
// rtl/matmul_mem_sequencer_dual_mac.sv - dual multiply-accumulate for two A/B element pairs per cycle
// Purpose: acc <= (load ? 0 : acc) + d0*d1 + d2*d3 when consume_i, 32-bit wrapping.
// Ports: clock, reset_n (async active-low); d0_i..d3_i read data; consume_i, load_i control;
//        acc_o registered accumulator.
module mem_dual_mac
   import matmul_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] d0_i,
   input  logic [DATA_W-1:0] d1_i,
   input  logic [DATA_W-1:0] d2_i,
   input  logic [DATA_W-1:0] d3_i,
   input  logic              consume_i,
   input  logic              load_i,
   output logic [ACC_W-1:0]  acc_o
);

   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] acc_q, acc_d;

   always_comb begin
      sum   = ACC_W'(d0_i) * ACC_W'(d1_i) + ACC_W'(d2_i) * ACC_W'(d3_i);
      acc_d = acc_q;
      // Loading on the first pair of an element removes the need for a clear cycle.
      if (consume_i) begin
         acc_d = load_i ? sum : acc_q + sum;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/matmul_mem_sequencer.sv
// rtl/matmul_mem_sequencer.sv - C = A x B sequencer driving the 4-port data memory
// Purpose: FSM, element indices and address generation; reads two A/B pairs per cycle,
//          writes each C element through port 0.
// Ports: clock, reset_n (async active-low); start; busy, done (pulse), overflow (sticky);
//        mem (master side of the four memory ports).
module matmul_mem_sequencer
   import matmul_pkg::*;
#(
   parameter int                N      = 4,
   parameter logic [ADDR_W-1:0] BASE_A = 8'd0,
   parameter logic [ADDR_W-1:0] BASE_B = 8'd16,
   parameter logic [ADDR_W-1:0] BASE_C = 8'd32
)(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   matmul_mem_sequencer_if.master mem
);

   localparam logic [ADDR_W-1:0] NV       = ADDR_W'(N);
   localparam logic [ADDR_W-1:0] F_LAST   = ADDR_W'(N / 2 - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, f_q, f_d;
   logic              ovf_q, ovf_d;
   logic              consume_q, consume_d, load_q, load_d;
   logic [ACC_W-1:0]  acc;
   logic [ADDR_W-1:0] two_f;

   mem_dual_mac u_mac (
      .clock     (clock),
      .reset_n   (reset_n),
      .d0_i      (mem.mem_dataout0),
      .d1_i      (mem.mem_dataout1),
      .d2_i      (mem.mem_dataout2),
      .d3_i      (mem.mem_dataout3),
      .consume_i (consume_q),
      .load_i    (load_q),
      .acc_o     (acc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         i_q       <= '0;
         j_q       <= '0;
         f_q       <= '0;
         ovf_q     <= 1'b0;
         consume_q <= 1'b0;
         load_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         f_q       <= f_d;
         ovf_q     <= ovf_d;
         consume_q <= consume_d;
         load_q    <= load_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      f_d       = f_q;
      ovf_d     = ovf_q;
      // Read data arrives one cycle after each FETCH cycle; f=0 data starts a new sum.
      consume_d = (state_q == ST_FETCH);
      load_d    = (state_q == ST_FETCH) && (f_q == '0);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ovf_d   = 1'b0;
               i_d     = '0;
               j_d     = '0;
               f_d     = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (f_q == F_LAST) begin
               state_d = ST_DRAIN;
            end else begin
               f_d = f_q + 8'd1;
            end
         end
         ST_DRAIN: state_d = ST_WRITE;
         ST_WRITE: begin
            if (acc[ACC_W-1:DATA_W] != '0) begin
               ovf_d = 1'b1;
            end
            f_d = '0;
            if (j_q == IDX_LAST) begin
               j_d = '0;
               if (i_q == IDX_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  i_d     = i_q + 8'd1;
                  state_d = ST_FETCH;
               end
            end else begin
               j_d     = j_q + 8'd1;
               state_d = ST_FETCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy              = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);
      done              = (state_q == ST_DONE);
      overflow          = ovf_q;
      two_f             = {f_q[ADDR_W-2:0], 1'b0};
      mem.mem_write_en0 = 1'b0;
      mem.mem_write_en1 = 1'b0;
      mem.mem_write_en2 = 1'b0;
      mem.mem_write_en3 = 1'b0;
      mem.mem_addr0     = '0;
      mem.mem_addr1     = '0;
      mem.mem_addr2     = '0;
      mem.mem_addr3     = '0;
      mem.mem_datain0   = '0;
      mem.mem_datain1   = '0;
      mem.mem_datain2   = '0;
      mem.mem_datain3   = '0;
      case (state_q)
         // DRAIN keeps f at its last value, so the FETCH addresses simply hold.
         ST_FETCH, ST_DRAIN: begin
            mem.mem_addr0 = elem_addr(BASE_A, i_q, two_f, NV);
            mem.mem_addr1 = elem_addr(BASE_B, two_f, j_q, NV);
            mem.mem_addr2 = elem_addr(BASE_A, i_q, two_f + 8'd1, NV);
            mem.mem_addr3 = elem_addr(BASE_B, two_f + 8'd1, j_q, NV);
         end
         ST_WRITE: begin
            mem.mem_write_en0 = 1'b1;
            mem.mem_addr0     = elem_addr(BASE_C, i_q, j_q, NV);
            mem.mem_datain0   = acc[DATA_W-1:0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// tb/tb_matmul_mem_sequencer.sv - self-checking bench for matmul_mem_sequencer
module tb_matmul_mem_sequencer;

   localparam int N      = 4;
   localparam int NN     = N * N;
   localparam int BASE_A = 0;
   localparam int BASE_B = 16;
   localparam int BASE_C = 32;
   localparam int PER    = N / 2 + 2;
   localparam int LAT    = NN * PER;
   localparam int LIMIT  = 4 * LAT;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic start   = 1'b0;
   logic busy, done, overflow;

   matmul_mem_sequencer_if mem_if();

   matmul_mem_sequencer #(
      .N      (N),
      .BASE_A (8'(BASE_A)),
      .BASE_B (8'(BASE_B)),
      .BASE_C (8'(BASE_C))
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .mem      (mem_if)
   );

   always #5 clock = ~clock;

   // Four-port memory with registered reads; a writing port keeps its dataout.
   logic [15:0] mem [256];
   logic [15:0] dout0_q, dout1_q, dout2_q, dout3_q;
   logic        bd_load = 1'b0;
   logic [15:0] a_mat [NN];
   logic [15:0] b_mat [NN];
   logic [31:0] exp_c [NN];
   logic        exp_ovf;

   assign mem_if.mem_dataout0 = dout0_q;
   assign mem_if.mem_dataout1 = dout1_q;
   assign mem_if.mem_dataout2 = dout2_q;
   assign mem_if.mem_dataout3 = dout3_q;

   always @(posedge clock) begin
      if (bd_load) begin
         for (int k = 0; k < NN; k++) begin
            mem[BASE_A + k] <= a_mat[k];
            mem[BASE_B + k] <= b_mat[k];
            mem[BASE_C + k] <= 16'hDEAD;
         end
      end else begin
         if (mem_if.mem_write_en0) mem[mem_if.mem_addr0] <= mem_if.mem_datain0;
         else                      dout0_q <= mem[mem_if.mem_addr0];
         if (mem_if.mem_write_en1) mem[mem_if.mem_addr1] <= mem_if.mem_datain1;
         else                      dout1_q <= mem[mem_if.mem_addr1];
         if (mem_if.mem_write_en2) mem[mem_if.mem_addr2] <= mem_if.mem_datain2;
         else                      dout2_q <= mem[mem_if.mem_addr2];
         if (mem_if.mem_write_en3) mem[mem_if.mem_addr3] <= mem_if.mem_datain3;
         else                      dout3_q <= mem[mem_if.mem_addr3];
      end
   end

   // Write monitor: logs every port-0 write and counts illegal port/address use.
   int          wr_total = 0;
   int          bad_port = 0;
   int          bad_addr = 0;
   logic [7:0]  log_addr [1024];
   logic [15:0] log_data [1024];

   always @(negedge clock) begin
      if (mem_if.mem_write_en1 || mem_if.mem_write_en2 || mem_if.mem_write_en3) bad_port++;
      if (mem_if.mem_write_en0) begin
         if (int'(mem_if.mem_addr0) < BASE_C || int'(mem_if.mem_addr0) >= BASE_C + NN) bad_addr++;
         if (wr_total < 1024) begin
            log_addr[wr_total] = mem_if.mem_addr0;
            log_data[wr_total] = mem_if.mem_datain0;
         end
         wr_total++;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain matrix product, 32-bit wrapping sums.
   task automatic compute_expected();
      logic [31:0] s;
      exp_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = 32'd0;
            for (int k = 0; k < N; k++) s = s + 32'(a_mat[i*N+k]) * 32'(b_mat[k*N+j]);
            exp_c[i*N+j] = s;
            if (s > 32'hFFFF) exp_ovf = 1'b1;
         end
      end
   endtask

   task automatic run_mult(input string name, input int restart_at, input int reset_at);
      int   edges, busy_cnt, done_cnt, done_at, base, n_exp, errs;
      logic part_ovf;
      compute_expected();
      @(negedge clock);
      bd_load = 1'b1;
      @(negedge clock);
      bd_load = 1'b0;
      base    = wr_total;
      start   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start    = 1'b0;
      edges    = 0;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      n_exp    = NN;
      check_eq({name, " ovf_clr"}, 32'(overflow), 32'd0);
      while (edges < LIMIT) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = edges;
         end
         if (edges == reset_at) begin
            n_exp    = (reset_at + 1) / PER;
            part_ovf = 1'b0;
            for (int k = 0; k < n_exp; k++) if (exp_c[k] > 32'hFFFF) part_ovf = 1'b1;
            check_eq({name, " ovf_pre_rst"}, 32'(overflow), 32'(part_ovf));
            reset_n = 1'b0;
            #1;
            check_eq({name, " rst_we0"}, 32'(mem_if.mem_write_en0), 32'd0);
            check_eq({name, " rst_busy"}, 32'(busy), 32'd0);
            check_eq({name, " rst_addr0"}, 32'(mem_if.mem_addr0), 32'd0);
            check_eq({name, " rst_ovf"}, 32'(overflow), 32'd0);
            break;
         end
         start = (edges == restart_at);
         if (done_at >= 0 && edges >= done_at + 6) break;
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
      start = 1'b0;
      if (reset_at >= 0) begin
         repeat (3) @(negedge clock);
         reset_n = 1'b1;
         check_eq({name, " part_wr"}, 32'(wr_total - base), 32'(n_exp));
      end else begin
         check_eq({name, " done_at"}, 32'(done_at), 32'(LAT));
         check_eq({name, " done_cnt"}, 32'(done_cnt), 32'd1);
         check_eq({name, " busy_cycles"}, 32'(busy_cnt), 32'(LAT));
         check_eq({name, " wr_cnt"}, 32'(wr_total - base), 32'(NN));
         check_eq({name, " overflow"}, 32'(overflow), 32'(exp_ovf));
         errs = 0;
         for (int k = 0; k < NN; k++) if (mem[BASE_C + k] !== exp_c[k][15:0]) errs++;
         check_eq({name, " c_mem_errs"}, 32'(errs), 32'd0);
      end
      for (int w = 0; w < n_exp && w < wr_total - base; w++) begin
         check_eq({name, " wr_addr"}, 32'(log_addr[base + w]), 32'(BASE_C + w));
         check_eq({name, " wr_data"}, 32'(log_data[base + w]), 32'(exp_c[w][15:0]));
      end
      check_eq({name, " we123"}, 32'(bad_port), 32'd0);
      check_eq({name, " wr_range"}, 32'(bad_addr), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst done", 32'(done), 32'd0);
      check_eq("rst overflow", 32'(overflow), 32'd0);
      check_eq("rst we0", 32'(mem_if.mem_write_en0), 32'd0);
      check_eq("rst addr0", 32'(mem_if.mem_addr0), 32'd0);
      check_eq("rst addr3", 32'(mem_if.mem_addr3), 32'd0);
      check_eq("rst datain0", 32'(mem_if.mem_datain0), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check_eq("idle busy", 32'(busy), 32'd0);

      for (int k = 0; k < NN; k++) begin
         a_mat[k] = (k / N == k % N) ? 16'd1 : 16'd0;
         b_mat[k] = 16'(k + 1);
      end
      run_mult("ident", -1, -1);
      check_eq("ident c_eq_b", 32'(mem[BASE_C + 5]), 32'd6);

      for (int k = 0; k < NN; k++) begin
         a_mat[k] = 16'd2;
         b_mat[k] = 16'd3;
      end
      run_mult("const", -1, -1);
      check_eq("const c_last", 32'(mem[BASE_C + NN - 1]), 32'h0018);

      for (int k = 0; k < NN; k++) begin
         a_mat[k] = 16'h0100;
         b_mat[k] = 16'h0100;
      end
      run_mult("ovf", -1, -1);
      check_eq("ovf flag_after", 32'(overflow), 32'd1);

      for (int k = 0; k < NN; k++) begin
         a_mat[k] = 16'($urandom_range(0, 255));
         b_mat[k] = 16'($urandom_range(0, 255));
      end
      run_mult("restart", 10, -1);

      for (int k = 0; k < NN; k++) begin
         a_mat[k] = 16'h0100;
         b_mat[k] = 16'h0100;
      end
      run_mult("midrst", -1, 20);

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NN; k++) begin
            a_mat[k] = (r < 2) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
            b_mat[k] = (r < 2) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
         end
         run_mult((r == 0) ? "post_rst" : "rand", -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
